// File: rtl/prefetch_fetcher.sv
// prefetch_fetcher
//   Instruction prefetcher sitting between a registered code ROM and the
//   decoder/executor. Sequential words are streamed from the ROM into a
//   circular word queue. The head WINDOW words are presented as one command
//   view under a valid/ready handshake. An accepted command either pops the
//   number of words the consumer reports, or redirects the stream by a signed
//   offset and flushes the queue.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   mem_rd_en       read request to the code memory (fetch credit available)
//   mem_addr        read address (current fetch pc)
//   mem_rdata       read data, returned the cycle after the request
//   out_valid       a full WINDOW-word view is presented
//   out_ready       consumer accepts the presented command
//   consume_size    words used by the accepted command (1..WINDOW)
//   jmp_flag        accepted command redirects the fetch stream
//   jmp_offset      signed offset relative to out_addr
//   out_cmd         head words, word i at [i*WORD_W +: WORD_W]
//   out_addr        address of out_cmd word 0
//   fill_level      words currently held in the queue
//   size_err        one-cycle pulse after an accept with an illegal size
module prefetch_fetcher #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int WINDOW = 3,
  parameter int DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [WORD_W-1:0]            mem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic [$clog2(WINDOW+1)-1:0]  consume_size,
  input  logic                         jmp_flag,
  input  logic [ADDR_W-1:0]            jmp_offset,
  output logic [WINDOW*WORD_W-1:0]     out_cmd,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         size_err
);

  localparam int CS_W  = $clog2(WINDOW + 1);
  localparam int FL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [FL_W:0]       DEPTH_X   = (FL_W + 1)'(DEPTH);
  localparam logic [FL_W-1:0]     WINDOW_FL = FL_W'(WINDOW);
  localparam logic [CS_W:0]       WINDOW_CS = (CS_W + 1)'(WINDOW);
  localparam logic [ADDR_W-1:0]   ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Queue storage and pointers
  logic [WORD_W-1:0] slot_q [DEPTH];
  logic [WORD_W-1:0] slot_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FL_W-1:0]   fill_level_q, fill_level_d;

  // A read was issued last cycle and its data is on mem_rdata now
  logic              inflight_q, inflight_d;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              size_err_q, size_err_d;

  // Decoded handshake events
  logic [CS_W:0]     cs_ext_s;
  logic              size_ok_s;
  logic              accept_s;
  logic              jump_s;
  logic              pop_s;
  logic              bad_s;
  logic              credit_s;
  logic              wr_s;
  logic [CS_W-1:0]   pop_cnt_s;
  logic [ADDR_W-1:0] target_s;

  // Handshake decode and fetch credit
  always_comb begin
    cs_ext_s  = {1'b0, consume_size};
    size_ok_s = (cs_ext_s != {(CS_W+1){1'b0}}) && (cs_ext_s <= WINDOW_CS);
    accept_s  = out_valid_q & out_ready;
    jump_s    = accept_s & jmp_flag;
    pop_s     = accept_s & ~jmp_flag & size_ok_s;
    bad_s     = accept_s & ~jmp_flag & ~size_ok_s;
    // Credit counts the word still in flight; a same-cycle pop does not
    // free a slot until the following cycle.
    credit_s  = ({1'b0, fill_level_q} + {{FL_W{1'b0}}, inflight_q}) < DEPTH_X;
    // Data returning in a redirect cycle belongs to the old stream.
    wr_s      = inflight_q & ~jump_s;
    if (pop_s) begin
      pop_cnt_s = consume_size;
    end else begin
      pop_cnt_s = {CS_W{1'b0}};
    end
    target_s  = out_addr_q + jmp_offset;
  end

  // Next-state computation for queue, pointers and fetch stream
  always_comb begin
    slot_d = slot_q;
    if (wr_s) begin
      slot_d[wr_ptr_q] = mem_rdata;
    end else begin
      slot_d = slot_q;
    end

    if (jump_s) begin
      // Flush: drop every queued word and the returning read.
      rd_ptr_d     = {PTR_W{1'b0}};
      wr_ptr_d     = {PTR_W{1'b0}};
      fill_level_d = {FL_W{1'b0}};
      inflight_d   = 1'b0;
      fetch_pc_d   = target_s;
      out_addr_d   = target_s;
    end else begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(pop_cnt_s);
      wr_ptr_d     = wr_ptr_q + PTR_W'(wr_s);
      fill_level_d = fill_level_q + FL_W'(wr_s) - FL_W'(pop_cnt_s);
      inflight_d   = mem_rd_en;
      if (mem_rd_en) begin
        fetch_pc_d = fetch_pc_q + ONE_A;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      out_addr_d   = out_addr_q + ADDR_W'(pop_cnt_s);
    end

    out_valid_d = (fill_level_d >= WINDOW_FL);
    size_err_d  = bad_s;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      fill_level_q <= {FL_W{1'b0}};
      inflight_q   <= 1'b0;
      fetch_pc_q   <= RESET_ADDR;
      out_addr_q   <= RESET_ADDR;
      out_valid_q  <= 1'b0;
      size_err_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_level_q <= fill_level_d;
      inflight_q   <= inflight_d;
      fetch_pc_q   <= fetch_pc_d;
      out_addr_q   <= out_addr_d;
      out_valid_q  <= out_valid_d;
      size_err_q   <= size_err_d;
    end
  end

  // Queue word storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  // Head-of-queue command view, wrapping around the circular buffer
  always_comb begin
    out_cmd = {(WINDOW*WORD_W){1'b0}};
    for (int i = 0; i < WINDOW; i++) begin
      out_cmd[i*WORD_W +: WORD_W] = slot_q[rd_ptr_q + PTR_W'(i)];
    end
  end

  // Requests are suppressed in a reset cycle so nothing is issued that the
  // reset would then have to discard.
  assign mem_rd_en  = rst_n & credit_s;
  assign mem_addr   = fetch_pc_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign fill_level = fill_level_q;
  assign size_err   = size_err_q;

endmodule

// File: tb/tb_prefetch_fetcher.sv
module tb_prefetch_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  consume_size;
  logic        jmp_flag;
  logic [31:0] jmp_offset;
  logic [95:0] out_cmd;
  logic [31:0] out_addr;
  logic [3:0]  fill_level;
  logic        size_err;

  prefetch_fetcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .consume_size (consume_size),
    .jmp_flag     (jmp_flag),
    .jmp_offset   (jmp_offset),
    .out_cmd      (out_cmd),
    .out_addr     (out_addr),
    .fill_level   (fill_level),
    .size_err     (size_err)
  );

  always #5 clk = ~clk;

  // Code memory: word at address a holds a, one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_addr;
  end

  typedef struct {
    logic [31:0] addr;
    bit          jmp;
    bit          bad;
    logic [31:0] tgt;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard compare on every accept
  int          jcnt = 0;
  logic [31:0] jtgt;
  bit          err_pend = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      jcnt = 0;
      err_pend = 0;
    end else begin
      chk("size_err", 64'(size_err), 64'(err_pend));
      err_pend = 0;
      chk("fill_bound", 64'(fill_level <= 4'd8), 64'd1);
      chk("valid_rule", 64'(out_valid), 64'(fill_level >= 4'd3));
      if (jcnt > 0) begin
        if (jcnt == 1) begin
          chk("jmp_rd_en", 64'(mem_rd_en), 64'd1);
          chk("jmp_addr", 64'(mem_addr), 64'(jtgt));
        end
        if (jcnt < 5) chk("jmp_bubble", 64'(out_valid), 64'd0);
        else          chk("jmp_refill", 64'(out_valid), 64'd1);
        jcnt = (jcnt == 5) ? 0 : jcnt + 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_addr", 64'(out_addr), 64'(e.addr));
          for (int i = 0; i < 3; i++) begin
            logic [31:0] w;
            w = e.addr + 32'(i);
            chk("out_cmd_word", 64'(out_cmd[i*32 +: 32]), 64'(w));
          end
          if (e.jmp) begin
            jcnt = 1;
            jtgt = e.tgt;
          end
          if (e.bad) err_pend = 1;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one command: model the expected view, push it, then hold the
  // controls until the DUT accepts. Caller is at posedge+1.
  task automatic issue(input logic [1:0] sz, input bit jf, input logic [31:0] off,
                       input bit rdy_always, output int cyc);
    exp_t e;
    bit   acc;
    e.addr = model_pc;
    e.jmp  = jf;
    e.bad  = !jf && (sz == 2'd0);
    e.tgt  = model_pc + off;
    if (jf)              model_pc = model_pc + off;
    else if (sz != 2'd0) model_pc = model_pc + 32'(sz);
    exp_q.push_back(e);
    consume_size = sz;
    jmp_flag     = jf;
    jmp_offset   = off;
    acc = 0;
    cyc = 0;
    while (!acc && cyc < 100) begin
      out_ready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = out_valid && out_ready;
      next_cycle();
      cyc++;
    end
    out_ready = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    int c;
    issue(2'($urandom_range(0, 3)), 1'b1, tgt - model_pc, 1'b1, c);
  endtask

  // Called in cycle 0 after reset release with out_ready low
  task automatic idle_check();
    int f;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      f = (c < 1) ? 0 : ((c - 1 > 8) ? 8 : c - 1);
      chk("idle_rd_en", 64'(mem_rd_en), 64'(c < 8));
      if (c < 8) chk("idle_mem_addr", 64'(mem_addr), 64'(c));
      chk("idle_fill", 64'(fill_level), 64'(f));
      chk("idle_valid", 64'(out_valid), 64'(c >= 4));
      chk("idle_out_addr", 64'(out_addr), 64'd0);
    end
    for (int i = 0; i < 3; i++) chk("idle_cmd_word", 64'(out_cmd[i*32 +: 32]), 64'(i));
    model_pc = 32'd0;
    next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n        = 1'b0;
    out_ready    = 1'b0;
    consume_size = 2'd0;
    jmp_flag     = 1'b0;
    jmp_offset   = 32'd0;
    model_pc     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check();

    // Illegal size: size_err pulse, no pop, no address change
    for (int k = 0; k < 2; k++) begin
      issue(2'd0, 1'b0, 32'($urandom), 1'b1, c);
      @(negedge clk);
      chk("bad_fill", 64'(fill_level), 64'd8);
      chk("bad_out_addr", 64'(out_addr), 64'd0);
      next_cycle();
    end

    // Back-to-back size-1 stream from a full queue: one accept per cycle
    for (int k = 0; k < 10; k++) begin
      issue(2'd1, 1'b0, 32'($urandom), 1'b1, c);
      chk("stream_cycles", 64'(c), 64'd1);
    end
    for (int k = 0; k < 4; k++) issue(2'd3, 1'b0, 32'd0, 1'b1, c);

    // Jump back from address 5 to 0
    jump_to(32'd5);
    issue(2'd0, 1'b1, 32'hFFFF_FFFB, 1'b1, c);
    // Address-space wrap: jump to top, jump +2, sequential wrap, tight loop
    jump_to(32'hFFFF_FFFF);
    issue(2'd2, 1'b1, 32'd2, 1'b1, c);
    jump_to(32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) issue(2'd1, 1'b0, 32'd0, 1'b1, c);
    issue(2'd3, 1'b1, 32'd0, 1'b1, c);
    issue(2'd3, 1'b0, 32'd0, 1'b1, c);

    // Randomized command stream with random ready backpressure
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       issue(2'($urandom_range(1, 3)), 1'b0, 32'($urandom), 1'b0, c);
      else if (r == 7) issue(2'd0, 1'b0, 32'($urandom), 1'b0, c);
      else             issue(2'($urandom_range(0, 3)), 1'b1,
                             32'($urandom_range(0, 40)) - 32'd20, 1'b0, c);
    end

    // Reset while the queue holds words and a read is in flight
    repeat (12) next_cycle();
    issue(2'd1, 1'b0, 32'd0, 1'b1, c);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    idle_check();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
